// File: rtl/inst_buffer_pkg.sv
// Shared constants for the instruction buffer between fetch stage 2 and decode.
// The packet layout, MSB first, is {instruction, pc, targetAddr, ctiqTag, prediction}.
package inst_buffer_pkg;

    localparam int unsigned SIZE_INSTRUCTION = 64;
    localparam int unsigned SIZE_PC          = 32;
    localparam int unsigned SIZE_CTI_LOG     = 4;
    localparam int unsigned SIZE_PREDICTION  = 1;

    localparam int unsigned PKT_W = SIZE_INSTRUCTION + 2 * SIZE_PC + SIZE_CTI_LOG
                                    + SIZE_PREDICTION;

    localparam int unsigned FETCH_WIDTH  = 4;
    localparam int unsigned DECODE_WIDTH = 4;
    localparam int unsigned IB_DEPTH     = 16;
    localparam int unsigned IB_DEPTH_LOG = $clog2(IB_DEPTH);

    // pc sits directly above targetAddr, ctiqTag and prediction
    localparam int unsigned PC_LSB = SIZE_PC + SIZE_CTI_LOG + SIZE_PREDICTION;

    function automatic logic [SIZE_PC-1:0] pktPc(input logic [PKT_W-1:0] pkt);
        return pkt[PC_LSB +: SIZE_PC];
    endfunction

endpackage

// File: rtl/inst_buffer_compact.sv
// Packs the valid fetch lanes into consecutive low slots, keeping lane order,
// and reports how many lanes are valid.
module inst_buffer_compact
    import inst_buffer_pkg::*;
#(
    parameter int unsigned FETCH_WIDTH = inst_buffer_pkg::FETCH_WIDTH,
    parameter int unsigned PKT_W       = inst_buffer_pkg::PKT_W,
    parameter int unsigned ENQ_W       = $clog2(FETCH_WIDTH + 1)
) (
    input  logic [FETCH_WIDTH-1:0]       valid_i,
    input  logic [FETCH_WIDTH*PKT_W-1:0] packets_i,
    output logic [FETCH_WIDTH*PKT_W-1:0] packets_o,
    output logic [ENQ_W-1:0]             enqN_o
);

    logic [ENQ_W-1:0] slot;

    always_comb begin
        packets_o = '0;
        slot      = '0;
        // slot is the number of valid lanes below lane k
        for (int k = 0; k < FETCH_WIDTH; k++) begin
            if (valid_i[k]) begin
                packets_o[slot*PKT_W +: PKT_W] = packets_i[k*PKT_W +: PKT_W];
                slot = slot + ENQ_W'(1);
            end
        end
        enqN_o = slot;
    end

endmodule

// File: rtl/inst_buffer.sv
// Circular instruction buffer: compacted multi-lane enqueue from fetch, in-order
// multi-lane presentation to decode, with a registered stall and flush.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int unsigned FETCH_WIDTH  = inst_buffer_pkg::FETCH_WIDTH,
    parameter int unsigned DECODE_WIDTH = inst_buffer_pkg::DECODE_WIDTH,
    parameter int unsigned DEPTH        = inst_buffer_pkg::IB_DEPTH,
    parameter int unsigned PKT_W        = inst_buffer_pkg::PKT_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          fs2Ready_i,
    input  logic [FETCH_WIDTH-1:0]        instValid_i,
    input  logic [FETCH_WIDTH*PKT_W-1:0]  instPacket_i,
    input  logic                          flush_i,
    input  logic                          decodeReady_i,
    output logic [DECODE_WIDTH-1:0]       decodeValid_o,
    output logic [DECODE_WIDTH*PKT_W-1:0] decodePacket_o,
    output logic                          stall_o,
    output logic [$clog2(DEPTH):0]        count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENQ_W = $clog2(FETCH_WIDTH + 1);

    logic [PKT_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] headQ, headD, tailQ, tailD;
    logic [CNT_W-1:0] countQ, countD;

    logic [FETCH_WIDTH*PKT_W-1:0] compPackets;
    logic [ENQ_W-1:0]             enqN;
    logic                         enqFire, deqFire;
    logic [CNT_W-1:0]             deqN, enqAmt, deqAmt;

    inst_buffer_compact #(
        .FETCH_WIDTH (FETCH_WIDTH),
        .PKT_W       (PKT_W),
        .ENQ_W       (ENQ_W)
    ) u_compact (
        .valid_i   (instValid_i),
        .packets_i (instPacket_i),
        .packets_o (compPackets),
        .enqN_o    (enqN)
    );

    // Stall looks only at the registered count so fetch sees no input-to-stall path.
    assign stall_o = countQ > CNT_W'(DEPTH - FETCH_WIDTH);
    assign count_o = countQ;

    assign enqFire = fs2Ready_i & ~stall_o & ~flush_i;
    assign deqFire = decodeReady_i & ~flush_i;
    assign deqN    = (countQ > CNT_W'(DECODE_WIDTH)) ? CNT_W'(DECODE_WIDTH) : countQ;
    assign enqAmt  = enqFire ? CNT_W'(enqN) : '0;
    assign deqAmt  = deqFire ? deqN : '0;

    always_comb begin
        headD  = headQ;
        tailD  = tailQ;
        countD = countQ;
        if (flush_i) begin
            headD  = '0;
            tailD  = '0;
            countD = '0;
        end else begin
            headD  = headQ + PTR_W'(deqAmt);
            tailD  = tailQ + PTR_W'(enqAmt);
            countD = countQ + enqAmt - deqAmt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            headQ  <= '0;
            tailQ  <= '0;
            countQ <= '0;
        end else begin
            headQ  <= headD;
            tailQ  <= tailD;
            countQ <= countD;
        end
    end

    // Storage holds no valid state of its own, so it is never cleared.
    always_ff @(posedge clk) begin
        if (enqFire) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                if (i < int'(enqN)) begin
                    mem[tailQ + PTR_W'(i)] <= compPackets[i*PKT_W +: PKT_W];
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < DECODE_WIDTH; k++) begin
            decodeValid_o[k]                  = countQ > CNT_W'(k);
            decodePacket_o[k*PKT_W +: PKT_W] = mem[headQ + PTR_W'(k)];
        end
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Bench for inst_buffer: a packet scoreboard tracks what decode should see,
// and each scenario task checks counts, stall and lane contents against it.
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    localparam int FW = FETCH_WIDTH;
    localparam int DW = DECODE_WIDTH;
    localparam int D  = IB_DEPTH;

    logic                   clk;
    logic                   reset;
    logic                   fs2Ready_i;
    logic [FW-1:0]          instValid_i;
    logic [FW*PKT_W-1:0]    instPacket_i;
    logic                   flush_i;
    logic                   decodeReady_i;
    logic [DW-1:0]          decodeValid_o;
    logic [DW*PKT_W-1:0]    decodePacket_o;
    logic                   stall_o;
    logic [$clog2(D):0]     count_o;

    logic [PKT_W-1:0] sb [$];
    int checks = 0;
    int errors = 0;

    inst_buffer dut (
        .clk            (clk),
        .reset          (reset),
        .fs2Ready_i     (fs2Ready_i),
        .instValid_i    (instValid_i),
        .instPacket_i   (instPacket_i),
        .flush_i        (flush_i),
        .decodeReady_i  (decodeReady_i),
        .decodeValid_o  (decodeValid_o),
        .decodePacket_o (decodePacket_o),
        .stall_o        (stall_o),
        .count_o        (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [PKT_W-1:0] mkPkt(input logic [SIZE_PC-1:0] pc);
        logic [SIZE_INSTRUCTION-1:0] ins;
        ins = {pc ^ 32'h5A5A_0F0F, ~pc};
        return {ins, pc, pc + 32'd4, pc[6:3], pc[3]};
    endfunction

    // Drives one cycle, updates the scoreboard from the pre-edge state, then
    // leaves the inputs idle 1 time unit after the edge.
    task automatic drive(input logic fsR, input logic [FW-1:0] v, input logic [31:0] base,
                         input logic decR, input logic fl);
        int  deqN;
        bit  stalled;
        fs2Ready_i    = fsR;
        instValid_i   = v;
        decodeReady_i = decR;
        flush_i       = fl;
        for (int k = 0; k < FW; k++) instPacket_i[k*PKT_W +: PKT_W] = mkPkt(base + 32'(8*k));
        if (fl) begin
            sb.delete();
        end else begin
            stalled = sb.size() > D - FW;
            deqN    = decR ? ((sb.size() < DW) ? sb.size() : DW) : 0;
            repeat (deqN) void'(sb.pop_front());
            if (fsR && !stalled)
                for (int k = 0; k < FW; k++)
                    if (v[k]) sb.push_back(mkPkt(base + 32'(8*k)));
        end
        @(posedge clk);
        #1;
        fs2Ready_i    = 1'b0;
        instValid_i   = '0;
        decodeReady_i = 1'b0;
        flush_i       = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (count_o !== '0) begin
            errors++; $display("FAIL reset_count got %0d want 0", count_o);
        end
        checks++;
        if (decodeValid_o !== '0) begin
            errors++; $display("FAIL reset_valid got %b want 0", decodeValid_o);
        end
        checks++;
        if (stall_o !== 1'b0) begin
            errors++; $display("FAIL reset_stall got %b want 0", stall_o);
        end
        reset = 1'b1;
    endtask

    task automatic test_full_bundle();
        drive(1'b1, 4'b1111, 32'h100, 1'b0, 1'b0);
        checks++;
        if (count_o !== 5'd4) begin
            errors++; $display("FAIL full_count got %0d want 4", count_o);
        end
        checks++;
        if (decodeValid_o !== 4'b1111) begin
            errors++; $display("FAIL full_valid got %b want 1111", decodeValid_o);
        end
        checks++;
        if (pktPc(decodePacket_o[0 +: PKT_W]) !== 32'h100) begin
            errors++;
            $display("FAIL full_lane0_pc got %h want 100", pktPc(decodePacket_o[0 +: PKT_W]));
        end
        checks++;
        if (decodePacket_o[3*PKT_W +: PKT_W] !== sb[3]) begin
            errors++; $display("FAIL full_lane3 got %h want %h",
                               decodePacket_o[3*PKT_W +: PKT_W], sb[3]);
        end
        // drain, then dequeue from empty
        for (int r = 0; r < 2; r++) begin
            drive(1'b0, 4'b0000, 32'h0, 1'b1, 1'b0);
            checks++;
            if (count_o !== '0 || decodeValid_o !== '0) begin
                errors++; $display("FAIL empty_deq%0d got count %0d valid %b want 0/0",
                                   r, count_o, decodeValid_o);
            end
        end
    endtask

    task automatic test_sparse();
        drive(1'b1, 4'b0101, 32'h200, 1'b0, 1'b0);
        checks++;
        if (count_o !== 5'd2) begin
            errors++; $display("FAIL sparse_count got %0d want 2", count_o);
        end
        checks++;
        if (decodeValid_o !== 4'b0011) begin
            errors++; $display("FAIL sparse_valid got %b want 0011", decodeValid_o);
        end
        checks++;
        if (pktPc(decodePacket_o[0 +: PKT_W]) !== 32'h200) begin
            errors++;
            $display("FAIL sparse_lane0_pc got %h want 200", pktPc(decodePacket_o[0 +: PKT_W]));
        end
        checks++;
        if (decodePacket_o[PKT_W +: PKT_W] !== mkPkt(32'h210)) begin
            errors++; $display("FAIL sparse_lane1 got pc %h want 210",
                               pktPc(decodePacket_o[PKT_W +: PKT_W]));
        end
        drive(1'b0, 4'b0000, 32'h0, 1'b1, 1'b0);
        checks++;
        if (count_o !== '0) begin
            errors++; $display("FAIL sparse_drain got %0d want 0", count_o);
        end
    endtask

    task automatic test_fill();
        logic [FW-1:0] pats [9];
        logic          decs [9];
        int            expCount [9];
        pats     = '{4'b1111, 4'b0111, 4'b0111, 4'b0111, 4'b1111, 4'b1111, 4'b0111, 4'b1111,
                     4'b1111};
        decs     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        expCount = '{4, 7, 10, 13, 13, 9, 12, 16, 16};
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, pats[i], 32'h1000 + 32'(i * 'h40), decs[i], 1'b0);
            checks++;
            if (int'(count_o) !== expCount[i]) begin
                errors++; $display("FAIL fill_count[%0d] got %0d want %0d",
                                   i, count_o, expCount[i]);
            end
            checks++;
            if (stall_o !== (expCount[i] > D - FW)) begin
                errors++; $display("FAIL fill_stall[%0d] got %b want %b",
                                   i, stall_o, expCount[i] > D - FW);
            end
        end
        for (int r = 0; r < 8 && sb.size() > 0; r++) begin
            for (int k = 0; k < DW; k++) begin
                checks++;
                if (decodeValid_o[k] !== (k < sb.size())) begin
                    errors++; $display("FAIL fill_drain_valid[%0d] got %b", k, decodeValid_o[k]);
                end else if (k < sb.size() && decodePacket_o[k*PKT_W +: PKT_W] !== sb[k]) begin
                    errors++; $display("FAIL fill_drain_pkt[%0d] got pc %h want pc %h", k,
                                       pktPc(decodePacket_o[k*PKT_W +: PKT_W]), pktPc(sb[k]));
                end
            end
            drive(1'b0, 4'b0000, 32'h0, 1'b1, 1'b0);
        end
        checks++;
        if (count_o !== '0 || sb.size() != 0) begin
            errors++; $display("FAIL fill_end got count %0d want 0", count_o);
        end
    endtask

    task automatic test_steady();
        logic [31:0] prevPc;
        drive(1'b1, 4'b1111, 32'h4000, 1'b0, 1'b0);
        prevPc = 32'h4000 - 32'd8;
        for (int c = 0; c < 40; c++) begin
            for (int k = 0; k < DW; k++) begin
                checks++;
                if (!decodeValid_o[k] ||
                    pktPc(decodePacket_o[k*PKT_W +: PKT_W]) !== prevPc + 32'(8 * (k + 1)) ||
                    decodePacket_o[k*PKT_W +: PKT_W] !== sb[k]) begin
                    errors++; $display("FAIL steady_lane[%0d][%0d] got pc %h want %h", c, k,
                                       pktPc(decodePacket_o[k*PKT_W +: PKT_W]),
                                       prevPc + 32'(8 * (k + 1)));
                end
            end
            prevPc = prevPc + 32'd32;
            drive(1'b1, 4'b1111, 32'h4000 + 32'((c + 1) * 32), 1'b1, 1'b0);
            checks++;
            if (count_o !== 5'd4) begin
                errors++; $display("FAIL steady_count[%0d] got %0d want 4", c, count_o);
            end
        end
        drive(1'b0, 4'b0000, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        drive(1'b1, 4'b1111, 32'h6000, 1'b0, 1'b0);
        drive(1'b1, 4'b0011, 32'h6020, 1'b0, 1'b0);
        checks++;
        if (count_o !== 5'd6) begin
            errors++; $display("FAIL flush_pre got %0d want 6", count_o);
        end
        drive(1'b1, 4'b1111, 32'h6040, 1'b1, 1'b1);
        checks++;
        if (count_o !== '0 || decodeValid_o !== '0 || stall_o !== 1'b0) begin
            errors++; $display("FAIL flush_clear got count %0d valid %b stall %b want 0/0/0",
                               count_o, decodeValid_o, stall_o);
        end
        drive(1'b1, 4'b0001, 32'h6080, 1'b0, 1'b0);
        checks++;
        if (count_o !== 5'd1 || decodePacket_o[0 +: PKT_W] !== mkPkt(32'h6080)) begin
            errors++; $display("FAIL flush_after got count %0d pc %h want 1 pc 6080",
                               count_o, pktPc(decodePacket_o[0 +: PKT_W]));
        end
        drive(1'b0, 4'b0000, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 4'b1111, 32'h7000, 1'b0, 1'b0);
        drive(1'b1, 4'b1111, 32'h7020, 1'b0, 1'b0);
        drive(1'b1, 4'b0001, 32'h7040, 1'b0, 1'b0);
        checks++;
        if (count_o !== 5'd9) begin
            errors++; $display("FAIL rstmid_pre got %0d want 9", count_o);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (count_o !== '0 || decodeValid_o !== '0 || stall_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_async got count %0d valid %b stall %b want 0/0/0",
                               count_o, decodeValid_o, stall_o);
        end
        sb.delete();
        fs2Ready_i    = 1'b1;
        instValid_i   = 4'b1111;
        decodeReady_i = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (count_o !== '0) begin
            errors++; $display("FAIL rstmid_held got %0d want 0", count_o);
        end
        fs2Ready_i    = 1'b0;
        instValid_i   = '0;
        decodeReady_i = 1'b0;
        reset         = 1'b1;
        drive(1'b1, 4'b0111, 32'h7100, 1'b0, 1'b0);
        checks++;
        if (count_o !== 5'd3 || decodeValid_o !== 4'b0111) begin
            errors++; $display("FAIL rstmid_after got count %0d valid %b want 3/0111",
                               count_o, decodeValid_o);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (decodePacket_o[k*PKT_W +: PKT_W] !== sb[k]) begin
                errors++; $display("FAIL rstmid_lane[%0d] got pc %h want pc %h", k,
                                   pktPc(decodePacket_o[k*PKT_W +: PKT_W]), pktPc(sb[k]));
            end
        end
        drive(1'b0, 4'b0000, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        fs2Ready_i    = 1'b0;
        instValid_i   = '0;
        instPacket_i  = '0;
        flush_i       = 1'b0;
        decodeReady_i = 1'b0;
        test_reset();
        test_full_bundle();
        test_sparse();
        test_fill();
        test_steady();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
